// File: rtl/gray_2_bin_pipe_pkg.sv
// gray_pkg: shared helpers for the pipelined Gray-to-binary decoder.
//   gray_chunk_size - bits resolved per pipeline stage (ceil(width/stages))
//   gray_chunk_hi/lo - bit range owned by stage k (hi < lo means empty chunk)
//   gray_payload_w  - width of the stage payload {valid, data, carry, step_err}
//   gray_multi_bit  - true when more than one bit of a difference word is set
package gray_pkg;

    // Widest code the step checker's helper handles.
    localparam int GRAY_MAX_W = 64;

    function automatic int gray_chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int gray_chunk_hi(input int width, input int ch, input int k);
        return width - 1 - k * ch;
    endfunction

    function automatic int gray_chunk_lo(input int width, input int ch, input int k);
        int lo;
        lo = width - (k + 1) * ch;
        return (lo < 0) ? 0 : lo;
    endfunction

    // valid + data + carry + step_err
    function automatic int gray_payload_w(input int width);
        return width + 3;
    endfunction

    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    function automatic logic gray_multi_bit(input logic [GRAY_MAX_W-1:0] diff);
        return (diff & (diff - GRAY_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_2_bin_stage.sv
// gray_2_bin_stage: one pipeline slice of the Gray-to-binary decoder.
// Resolves binary bits [HI:LO] of the word from the incoming carry (the last
// binary bit resolved upstream) and registers the payload when en_i is high.
// An empty chunk (HI < LO) passes the payload through a register unchanged.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   en_i         - global pipeline advance
//   pl_i         - incoming payload {valid, data, carry, step_err}
//   pl_o         - registered payload
module gray_2_bin_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic [gray_payload_w(WIDTH)-1:0]  pl_i,
    output logic [gray_payload_w(WIDTH)-1:0]  pl_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             step_err;
    } payload_t;

    payload_t in_s;
    payload_t pl_d;
    payload_t pl_q;

    assign in_s = pl_i;

    // Prefix XOR from the MSB side of this chunk; carry ends as the lowest
    // resolved binary bit so the next stage can continue the chain.
    always_comb begin
        pl_d = in_s;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
                pl_d.carry   = pl_d.carry ^ in_s.data[i];
                pl_d.data[i] = pl_d.carry;
            end
        end
    end

    // Stage register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pl_q <= '0;
        end else if (en_i) begin
            pl_q <= pl_d;
        end
    end

    assign pl_o = pl_q;

endmodule

// File: rtl/gray_2_bin_pipe.sv
// gray_2_bin_pipe: pipelined Gray-to-binary decoder with valid/ready stream
// interface and a single-bit-step integrity checker.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   gray_i         - Gray code input, qualified by in_valid_i
//   in_ready_o     - block accepts gray_i this cycle
//   bin_o          - decoded binary, qualified by out_valid_o
//   step_err_o     - this beat differed from the previous accepted code in >1 bit
//   out_ready_i    - downstream accepts the output beat
//   clr_err_i      - clears err_sticky_o (a simultaneous new error wins)
//   err_sticky_o   - a step error was consumed since reset or last clear
// WIDTH must be in 2..GRAY_MAX_W, STAGES in 1..WIDTH.
module gray_2_bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             step_err_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             clr_err_i,
    output logic             err_sticky_o
);

    localparam int CH = gray_chunk_size(WIDTH, STAGES);
    localparam int PW = gray_payload_w(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             step_err;
    } payload_t;

    logic             en;
    logic             accept;
    logic             step_err;
    payload_t         head_s;
    payload_t         tail_s;
    logic [PW-1:0]    pl [STAGES+1];

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             sticky_q, sticky_d;
    logic             unused_carry;

    // Single global enable: the whole pipe advances or holds together, so
    // in-flight capacity is exactly STAGES beats.
    assign en         = !tail_s.valid || out_ready_i;
    assign in_ready_o = en;
    assign accept     = in_valid_i && en;

    // Step checker: compared against the previously accepted code only.
    assign step_err = prev_valid_q && gray_multi_bit(GRAY_MAX_W'(prev_q ^ gray_i));

    // Carry into the MSB is 0, so bin[WIDTH-1] = gray[WIDTH-1].
    always_comb begin
        head_s.valid    = in_valid_i;
        head_s.data     = gray_i;
        head_s.carry    = 1'b0;
        head_s.step_err = step_err;
    end

    assign pl[0] = head_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI_K = gray_chunk_hi(WIDTH, CH, k);
        localparam int LO_K = gray_chunk_lo(WIDTH, CH, k);
        gray_2_bin_stage #(
            .WIDTH (WIDTH),
            .HI    (HI_K),
            .LO    (LO_K)
        ) u_stage (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (en),
            .pl_i  (pl[k]),
            .pl_o  (pl[k+1])
        );
    end

    assign tail_s       = pl[STAGES];
    assign unused_carry = tail_s.carry;

    assign out_valid_o  = tail_s.valid;
    assign bin_o        = tail_s.data;
    assign step_err_o   = tail_s.step_err;
    assign err_sticky_o = sticky_q;

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (accept) begin
            prev_d       = gray_i;
            prev_valid_d = 1'b1;
        end
        sticky_d = sticky_q;
        if (clr_err_i) begin
            sticky_d = 1'b0;
        end
        if (tail_s.valid && out_ready_i && tail_s.step_err) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            prev_valid_q <= prev_valid_d;
            sticky_q     <= sticky_d;
        end
    end

    // History word is only meaningful while prev_valid_q is set.
    always_ff @(posedge clk_i) begin
        prev_q <= prev_d;
    end

endmodule
